// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path.
//   SEG7_W / NIBBLE_W : segment-pattern and hex-digit widths.
//   SEG7_LIT_CODE     : lit pattern (gfedcba, 1 = lit) for each hex value,
//                       indexed by the value itself. The display driver's
//                       checker uses the same table.
//   cap_state_e       : capture FSM states.
package seg7_pkg;

    localparam int SEG7_W   = 7;
    localparam int NIBBLE_W = 4;

    // Entry [15] is written first, so the list reads F down to 0.
    localparam logic [15:0][SEG7_W-1:0] SEG7_LIT_CODE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } cap_state_e;

endpackage

// File: rtl/seg7_pattern_match.sv
// Combinational decoder from a normalised (1 = lit) 7-segment pattern to the
// hex value it displays.
// Ports:
//   i_lit    : segment pattern, bit0 = a ... bit6 = g, 1 = lit.
//   o_nibble : decoded hex value; 0 when the pattern is not a legal glyph.
//   o_legal  : 1 when i_lit exactly matches one of the 16 glyphs.
import seg7_pkg::*;

module seg7_pattern_match (
    input  logic [SEG7_W-1:0]   i_lit,
    output logic [NIBBLE_W-1:0] o_nibble,
    output logic                o_legal
);

    // The 16 glyphs are all distinct, so at most one entry can match.
    always_comb begin
        o_nibble = '0;
        o_legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_lit == SEG7_LIT_CODE[i]) begin
                o_nibble = NIBBLE_W'(i);
                o_legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_pattern_capture.sv
// Reverse path of the HEX display driver: takes one 7-segment pattern per
// handshake, decodes it to a hex digit and assembles NUM_DIGITS digits into a
// word presented on a valid/ready output. Patterns that are not legal glyphs
// decode to 0 and are flagged in word_err_mask.
// Parameters:
//   NUM_DIGITS : digits per word (1..8).
//   ACTIVE_LOW : 1 = segment bit 0 means lit, 0 = segment bit 1 means lit.
// Ports:
//   clk, resetn           : clock (rising edge), async active-low reset.
//   sync_clr              : synchronous abort of the partial or held word.
//   seg_in/seg_valid/seg_ready     : digit input handshake.
//   word_data/word_err_mask/word_valid/word_ready : word output handshake;
//                           first-accepted digit lands in the top nibble.
// Optional build macro SEG7_CAPTURE_DP_EN adds seg_dp (same polarity as
// seg_in) and word_dp (lit state of each digit's decimal point).
import seg7_pkg::*;

module seg7_pattern_capture #(
    parameter int NUM_DIGITS = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           sync_clr,
    input  logic [SEG7_W-1:0]              seg_in,
    input  logic                           seg_valid,
    output logic                           seg_ready,
    output logic [NIBBLE_W*NUM_DIGITS-1:0] word_data,
    output logic [NUM_DIGITS-1:0]          word_err_mask,
    output logic                           word_valid,
    input  logic                           word_ready
`ifdef SEG7_CAPTURE_DP_EN
    ,
    input  logic                           seg_dp,
    output logic [NUM_DIGITS-1:0]          word_dp
`endif
);

    localparam int WORD_W = NIBBLE_W * NUM_DIGITS;
    localparam int CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

    cap_state_e            r_state;
    cap_state_e            w_state_nxt;
    logic [CNT_W-1:0]      r_count;
    logic [WORD_W-1:0]     r_word;
    logic [NUM_DIGITS-1:0] r_mask;

    logic [SEG7_W-1:0]     w_seg_lit;
    logic [NIBBLE_W-1:0]   w_nibble;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_last;

    // Decode always works on lit-high patterns.
    assign w_seg_lit = (ACTIVE_LOW != 0) ? ~seg_in : seg_in;

    seg7_pattern_match u_match (
        .i_lit    (w_seg_lit),
        .o_nibble (w_nibble),
        .o_legal  (w_legal)
    );

    // Handshake outputs depend only on the registered state, so there is no
    // combinational path from seg_valid or word_ready to either of them.
    assign seg_ready  = (r_state == COLLECT);
    assign word_valid = (r_state == HOLD);

    // A digit offered in the same cycle as sync_clr is dropped.
    assign w_accept = seg_valid && (r_state == COLLECT) && !sync_clr;
    assign w_last   = w_accept && (r_count == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (sync_clr) begin
            w_state_nxt = COLLECT;
        end else begin
            case (r_state)
                COLLECT: if (w_last)     w_state_nxt = HOLD;
                HOLD:    if (word_ready) w_state_nxt = COLLECT;
                default:                 w_state_nxt = COLLECT;
            endcase
        end
    end

    // word_data is deliberately left alone on sync_clr and on leaving HOLD:
    // the previous word stays visible until the next digit shifts in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_word  <= '0;
            r_mask  <= '0;
        end else if (sync_clr) begin
            r_count <= '0;
            r_mask  <= '0;
        end else if (w_accept) begin
            r_word  <= (r_word << NIBBLE_W) | WORD_W'(w_nibble);
            r_mask  <= (r_mask << 1) | NUM_DIGITS'(!w_legal);
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

    assign word_data     = r_word;
    assign word_err_mask = r_mask;

`ifdef SEG7_CAPTURE_DP_EN
    logic                  w_dp_lit;
    logic [NUM_DIGITS-1:0] r_dp;

    assign w_dp_lit = (ACTIVE_LOW != 0) ? ~seg_dp : seg_dp;

    // The decimal point rides along with the digits but never affects legality.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dp <= '0;
        end else if (sync_clr) begin
            r_dp <= '0;
        end else if (w_accept) begin
            r_dp <= (r_dp << 1) | NUM_DIGITS'(w_dp_lit);
        end
    end

    assign word_dp = r_dp;
`endif

endmodule

// File: tb/tb_seg7_pattern_capture.sv
module tb_seg7_pattern_capture;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sync_clr;

    // DUT A: NUM_DIGITS=4, ACTIVE_LOW=1
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_ready;
    logic [15:0] word_data;
    logic [3:0]  word_err_mask;
    logic        word_valid;
    logic        word_ready;

    // DUT B: NUM_DIGITS=2, ACTIVE_LOW=0
    logic [6:0]  seg_in2;
    logic        seg_valid2;
    logic        seg_ready2;
    logic [7:0]  word_data2;
    logic [1:0]  word_err_mask2;
    logic        word_valid2;
    logic        word_ready2;

`ifdef SEG7_CAPTURE_DP_EN
    logic        seg_dp;
    logic [3:0]  word_dp;
    logic        seg_dp2;
    logic [1:0]  word_dp2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_pattern_capture #(.NUM_DIGITS(4), .ACTIVE_LOW(1)) dut_a (
        .clk           (clk),
        .resetn        (resetn),
        .sync_clr      (sync_clr),
        .seg_in        (seg_in),
        .seg_valid     (seg_valid),
        .seg_ready     (seg_ready),
        .word_data     (word_data),
        .word_err_mask (word_err_mask),
        .word_valid    (word_valid),
        .word_ready    (word_ready)
`ifdef SEG7_CAPTURE_DP_EN
        ,
        .seg_dp        (seg_dp),
        .word_dp       (word_dp)
`endif
    );

    seg7_pattern_capture #(.NUM_DIGITS(2), .ACTIVE_LOW(0)) dut_b (
        .clk           (clk),
        .resetn        (resetn),
        .sync_clr      (sync_clr),
        .seg_in        (seg_in2),
        .seg_valid     (seg_valid2),
        .seg_ready     (seg_ready2),
        .word_data     (word_data2),
        .word_err_mask (word_err_mask2),
        .word_valid    (word_valid2),
        .word_ready    (word_ready2)
`ifdef SEG7_CAPTURE_DP_EN
        ,
        .seg_dp        (seg_dp2),
        .word_dp       (word_dp2)
`endif
    );

    // Offer one digit to DUT A across one rising edge; seg_valid stays high.
    task automatic push(input logic [6:0] s);
        seg_in    = s;
        seg_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic release_word();
        seg_valid  = 1'b0;
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; sync_clr = 1'b0;
        seg_in = 7'h7F; seg_valid = 1'b0; word_ready = 1'b0;
        seg_in2 = 7'h00; seg_valid2 = 1'b0; word_ready2 = 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
        seg_dp = 1'b1; seg_dp2 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL reset_seg_ready got=%b exp=1", seg_ready); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
        checks++; if (word_data !== 16'h0000) begin errors++; $display("FAIL reset_word_data got=%h exp=0000", word_data); end
        checks++; if (word_err_mask !== 4'b0000) begin errors++; $display("FAIL reset_mask got=%b exp=0000", word_err_mask); end
        checks++; if (seg_ready2 !== 1'b1) begin errors++; $display("FAIL reset_seg_ready2 got=%b exp=1", seg_ready2); end
    endtask

    task automatic test_basic();
        push(7'h79); push(7'h24); push(7'h30);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got=%b exp=0", word_valid); end
        push(7'h19);
        seg_valid = 1'b0;
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_latency got=%b exp=1", word_valid); end
        checks++; if (word_data !== 16'h1234) begin errors++; $display("FAIL basic_data got=%h exp=1234", word_data); end
        checks++; if (word_err_mask !== 4'b0000) begin errors++; $display("FAIL basic_mask got=%b exp=0000", word_err_mask); end
        checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_hold got=%b exp=0", seg_ready); end
`ifdef SEG7_CAPTURE_DP_EN
        checks++; if (word_dp !== 4'b0000) begin errors++; $display("FAIL basic_dp got=%b exp=0000", word_dp); end
`endif
        release_word();
        checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got=%b exp=1", seg_ready); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got=%b exp=0", word_valid); end
        checks++; if (word_data !== 16'h1234) begin errors++; $display("FAIL basic_data_kept got=%h exp=1234", word_data); end
    endtask

    task automatic test_letters();
        push(7'h08); push(7'h03); push(7'h46); push(7'h21);
        seg_valid = 1'b0;
        checks++; if (word_data !== 16'hABCD) begin errors++; $display("FAIL letters_data got=%h exp=abcd", word_data); end
        checks++; if (word_err_mask !== 4'b0000) begin errors++; $display("FAIL letters_mask got=%b exp=0000", word_err_mask); end
        release_word();
        // Blank pattern (all segments off) as the second digit.
        push(7'h79); push(7'h7F); push(7'h30); push(7'h19);
        seg_valid = 1'b0;
        checks++; if (word_data !== 16'h1034) begin errors++; $display("FAIL illegal_data got=%h exp=1034", word_data); end
        checks++; if (word_err_mask !== 4'b0100) begin errors++; $display("FAIL illegal_mask got=%b exp=0100", word_err_mask); end
        release_word();
    endtask

    task automatic test_backpressure();
        push(7'h40); push(7'h79); push(7'h24); push(7'h30);
        seg_in = 7'h19;
        for (int i = 0; i < 5; i++) begin
            checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, seg_ready); end
            checks++; if (word_data !== 16'h0123) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=0123", i, word_data); end
            @(posedge clk); #1;
        end
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got=%b exp=1", seg_ready); end
        checks++; if (word_data !== 16'h0123) begin errors++; $display("FAIL bp_no_accept_in_hold got=%h exp=0123", word_data); end
        @(posedge clk); #1;
        checks++; if (word_data !== 16'h1234) begin errors++; $display("FAIL bp_next_digit got=%h exp=1234", word_data); end
        push(7'h40); push(7'h40); push(7'h40);
        seg_valid = 1'b0;
        checks++; if (word_data !== 16'h4000 || word_valid !== 1'b1) begin errors++; $display("FAIL bp_next_word got=%h/%b exp=4000/1", word_data, word_valid); end
        release_word();
    endtask

    task automatic test_sync_clr();
        // word_ready during COLLECT must have no effect.
        word_ready = 1'b1;
        push(7'h79); push(7'h24);
        word_ready = 1'b0;
        seg_in = 7'h30; seg_valid = 1'b1; sync_clr = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0; seg_valid = 1'b0;
        checks++; if (word_data[3:0] !== 4'h2) begin errors++; $display("FAIL clr_dropped got=%h exp=2", word_data[3:0]); end
        checks++; if (seg_ready !== 1'b1 || word_err_mask !== 4'b0000) begin errors++; $display("FAIL clr_state got=%b/%b exp=1/0000", seg_ready, word_err_mask); end
        push(7'h40); push(7'h40); push(7'h40);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL clr_count_reset got=%b exp=0", word_valid); end
        push(7'h79);
        seg_valid = 1'b0;
        checks++; if (word_data !== 16'h0001 || word_valid !== 1'b1) begin errors++; $display("FAIL clr_fresh_word got=%h/%b exp=0001/1", word_data, word_valid); end
        // Abort while holding a word that has an illegal digit.
        release_word();
        push(7'h7F); push(7'h40); push(7'h40); push(7'h40);
        seg_valid = 1'b0;
        sync_clr = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0;
        checks++; if (word_valid !== 1'b0 || seg_ready !== 1'b1) begin errors++; $display("FAIL clr_in_hold got=%b/%b exp=0/1", word_valid, seg_ready); end
        checks++; if (word_err_mask !== 4'b0000) begin errors++; $display("FAIL clr_hold_mask got=%b exp=0000", word_err_mask); end
    endtask

    task automatic test_async_reset();
        push(7'h79); push(7'h24); push(7'h30); push(7'h19);
        seg_valid = 1'b0;
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got=%b exp=1", word_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", word_valid); end
        checks++; if (word_data !== 16'h0000) begin errors++; $display("FAIL ar_data got=%h exp=0000", word_data); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (seg_ready !== 1'b1 || word_valid !== 1'b0) begin errors++; $display("FAIL ar_release got=%b/%b exp=1/0", seg_ready, word_valid); end
    endtask

    task automatic test_active_high();
        seg_in2 = 7'h6F; seg_valid2 = 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
        seg_dp2 = 1'b1;
`endif
        @(posedge clk); #1;
        seg_in2 = 7'h3F;
`ifdef SEG7_CAPTURE_DP_EN
        seg_dp2 = 1'b0;
`endif
        @(posedge clk); #1;
        seg_valid2 = 1'b0;
        checks++; if (word_data2 !== 8'h90) begin errors++; $display("FAIL ah_data got=%h exp=90", word_data2); end
        checks++; if (word_valid2 !== 1'b1 || word_err_mask2 !== 2'b00) begin errors++; $display("FAIL ah_valid_mask got=%b/%b exp=1/00", word_valid2, word_err_mask2); end
`ifdef SEG7_CAPTURE_DP_EN
        checks++; if (word_dp2 !== 2'b10) begin errors++; $display("FAIL ah_dp got=%b exp=10", word_dp2); end
`endif
        word_ready2 = 1'b1;
        @(posedge clk); #1;
        word_ready2 = 1'b0;
        seg_in2 = 7'h00; seg_valid2 = 1'b1;
        @(posedge clk); #1;
        seg_in2 = 7'h06;
        @(posedge clk); #1;
        seg_valid2 = 1'b0;
        checks++; if (word_data2 !== 8'h01) begin errors++; $display("FAIL ah_blank_data got=%h exp=01", word_data2); end
        checks++; if (word_err_mask2 !== 2'b10) begin errors++; $display("FAIL ah_blank_mask got=%b exp=10", word_err_mask2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_letters();
        test_backpressure();
        test_sync_clr();
        test_async_reset();
        test_active_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_pattern_capture.md
Name: seg7_pattern_capture

Overview:
- Reverse path of the HEX display driver: accepts a stream of 7-segment patterns, one per handshake, and decodes each back to its 4-bit hex value.
- Assembles NUM_DIGITS digits into a word, flagging any pattern that is not one of the 16 legal glyphs.
- Presents the word on a valid/ready output. Used as a checker/loopback on the display bus and as a segment-to-value reader for lab test harnesses.

Parameters:
- NUM_DIGITS, 4, digits per word; legal range 1..8.
- ACTIVE_LOW, 1, 1: a segment bit of 0 means lit (DE-board HEX convention); 0: a bit of 1 means lit.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sync_clr  in  1  synchronous abort; discards the partial or held word.
- seg_in  in  7  segment pattern; bit0=a, bit1=b … bit6=g.
- seg_valid  in  1  seg_in is valid.
- seg_ready  out  1  block can accept a digit.
- word_data  out  4*NUM_DIGITS  assembled word; first-accepted digit in the top nibble.
- word_err_mask  out  NUM_DIGITS  bit i set means the nibble at word_data[4i+3:4i] came from an illegal pattern.
- word_valid  out  1  word_data and word_err_mask are valid.
- word_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (resetn=0, async): state=COLLECT, digit count=0, word_data=0, word_err_mask=0, word_valid=0. seg_ready reads 1 once resetn is released.
- Normalisation: when ACTIVE_LOW=1, seg_in is inverted internally so that 1 means lit.
- Decode is exact-match against the canonical lit table (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other pattern decodes to nibble 0 and is marked illegal.
- FSM COLLECT:
  - seg_ready=1, word_valid=0.
  - On seg_valid&seg_ready, the decoded nibble shifts into word_data from the bottom (word_data <= {word_data<<4 | nibble}); word_err_mask shifts the same way with the illegal flag; count increments.
  - When the accepted digit is number NUM_DIGITS, go to HOLD next cycle with count=0.
- FSM HOLD:
  - seg_ready=0, word_valid=1.
  - word_data and word_err_mask are stable while word_valid=1.
  - On word_ready=1, go to COLLECT next cycle; the held data stays until the first new digit overwrites it.
- Latency and throughput:
  - word_valid rises exactly 1 cycle after the final digit handshake.
  - Minimum period is NUM_DIGITS+1 cycles per word; there is no accept-while-holding bypass.
- sync_clr:
  - Highest priority below reset.
  - In either state, next cycle: state=COLLECT, count=0, word_err_mask=0, word_valid=0.
  - A digit handshaking in the same cycle is dropped.
- Simultaneous events: word_ready while in COLLECT is ignored. seg_valid while in HOLD is not accepted, because seg_ready=0.
- Reset asserted mid-word: all state is lost immediately; no partial word is ever emitted.
- Each output bit is registered or a pure function of state; there are no combinational paths from seg_valid to seg_ready or from word_ready to word_valid.

Optional Feature:
- Macro: SEG7_CAPTURE_DP_EN.
- Defined:
  - Adds input seg_dp (1 bit, same polarity as seg_in) and output word_dp (NUM_DIGITS bits).
  - word_dp shifts alongside the nibbles and holds the normalised lit state of the decimal point.
  - The dp state never affects legality.
- Undefined: neither port exists; the decimal point is not modelled.

Decomposition:
- Package seg7_pkg holds:
  - SEG7_W=7 and NIBBLE_W=4.
  - SEG7_LIT_CODE, a 16-entry table of lit patterns indexed by hex value (shared with the display driver's checker).
  - The state enum {COLLECT, HOLD}.
- One sub-module, seg7_pattern_match: combinational, lit pattern in, nibble plus legal flag out.
- Counter, shift registers and FSM stay in the top.

Test Plan:
- ACTIVE_LOW=1, NUM_DIGITS=4; send 79,24,30,19 back-to-back → word_valid 1 cycle after the 4th handshake, word_data=16'h1234, word_err_mask=4'b0000.
- Send 08,03,46,21 (A,b,C,d active-low) → word_data=16'hABCD, mask=0. Then send 7F as the 2nd digit of the next word (blank) → nibble 0 at [11:8], mask=4'b0100.
- Backpressure: complete a word, hold word_ready=0 for 5 cycles with seg_valid=1 → seg_ready=0 and word_data stable throughout. Then pulse word_ready → seg_ready=1 on the next cycle; the next digit is accepted.
- After 2 digits are accepted, pulse sync_clr together with a 3rd seg_valid → that digit is dropped. Four fresh digits 40,40,40,79 → word 16'h0001.
- Assert resetn=0 asynchronously during HOLD → word_valid=0 and word_data=0 immediately. After release, seg_ready=1.
- ACTIVE_LOW=0, NUM_DIGITS=2; send 6F,3F → word 8'h90. With SEG7_CAPTURE_DP_EN and seg_dp=1 on the first digit → word_dp=2'b10.
